const_encoder: RTL and testbench
================================

# const_encoder

- Streaming immediate encoder for the 32-bit RISC toolchain/loader path. It is the inverse of the decode-stage constant extension.
- Accepts 32-bit constants over a valid/ready handshake. Emits the 15-bit immediate field(s) plus the CS (sign-extend select) bit that the decode stage expands back to the original value.
- A constant that fits one immediate goes out as a single beat. Any other constant is split into a three-beat HI/MID/LO sequence, which is rebuilt as ((HI<<15)|MID)<<15|LO.

## Interface

Parameters: none (all widths fixed by the ISA).

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  IN_DATA is valid
- IN_READY  out  1  encoder accepts IN_DATA this cycle
- IN_DATA  in  32  constant to encode
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  downstream accepts beat
- OUT_IM  out  15  immediate field
- OUT_CS  out  1  1 = sign-extend at decode, 0 = zero-extend
- OUT_TAG  out  2  0 SINGLE, 1 HI, 2 MID, 3 LO
- OUT_LAST  out  1  final beat of this constant

## Operation

- Classification of an accepted IN_DATA = D, in priority order:
  - Zero-fit: D[31:15]==0 → one beat, IM=D[14:0], CS=0, TAG=SINGLE.
  - Sign-fit: D[31:14] all ones (−16384..−1) → one beat, IM=D[14:0], CS=1, TAG=SINGLE. Gated by the macro below.
  - Otherwise, three beats, all with CS=0:
    - HI: IM={13'b0,D[31:30]}
    - MID: IM=D[29:15]
    - LO: IM=D[14:0]
- Zero-fit wins over sign-fit. Values 16384..32767 always encode with CS=0.
- State machine:
  - IDLE: can accept input.
  - On accepting a multi-beat constant: load the HI beat and go to EMIT_MID. D[29:0] is held internally.
  - EMIT_MID: on output handshake, load the MID beat and go to EMIT_LO.
  - EMIT_LO: on output handshake, load the LO beat and go to IDLE.
  - The LO beat drains from IDLE like a single beat.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). It is 0 throughout EMIT_MID and EMIT_LO.
- Simultaneous input accept and output handshake in IDLE: the new beat replaces the old one in the same edge. There are no bubbles.
- In IDLE, an output handshake with no new input clears OUT_VALID at the next edge.
- OUT_LAST = 1 for SINGLE and LO beats, 0 for HI and MID.

## Timing

- Reset (asynchronous, immediate): OUT_VALID=0, OUT_IM=0, OUT_CS=0, OUT_TAG=0, OUT_LAST=0, state=IDLE, internal hold register=0. IN_READY reads 1 after release.
- Latency: first beat is valid one cycle after the input handshake. All outputs are registered.
- Throughput: one single-beat constant per cycle. A multi-beat constant occupies 3 output cycles at minimum.
- While OUT_VALID && !OUT_READY, the encoder holds OUT_IM, OUT_CS, OUT_TAG and OUT_LAST stable.
- Reset asserted mid-sequence (any state): the in-flight constant is dropped. No partial beats appear after reset release.
- IN_DATA is ignored when IN_VALID=0 or IN_READY=0.

## Configuration

- CONST_ENC_SIGNED_EN:
  - Defined: the sign-fit single-beat path is present as described.
  - Undefined: no sign-fit path. Negative constants always use the three-beat form, and OUT_CS is constant 0.

## Structure

- Package const_enc_pkg holds:
  - tag typedef (SINGLE/HI/MID/LO)
  - state typedef (IDLE/EMIT_MID/EMIT_LO)
  - constants IM_W=15, DATA_W=32, HI_W=2
- Sub-module const_fit_check is a combinational classifier.
  - Input: D.
  - Outputs: zero_fit, sign_fit (tied 0 without the macro).
  - The top level holds the FSM, the beat register and the hold register.

## Test plan

- 0x00001234 with OUT_READY=1 → one beat, IM=0x1234, CS=0, TAG=0, LAST=1, valid one cycle after accept.
- 0xFFFFC000:
  - With macro → one beat, IM=0x4000, CS=1.
  - Without macro → HI 0x0003, MID 0x7FFF, LO 0x4000, CS=0.
- 0xDEADBEEF → HI 0x0003, MID 0x3D5B, LO 0x3EEF, tags 1/2/3, LAST only on LO, IN_READY=0 for two cycles. 0x00008000 → HI 0x0000, MID 0x0001, LO 0x0000.
- Backpressure: OUT_READY low for 3 cycles during the MID beat of 0xDEADBEEF → MID beat stable, IN_READY=0, then LO follows the cycle after OUT_READY rises.
- Back-to-back 0x1, 0x2, 0x3 with IN_VALID and OUT_READY held high → SINGLE beats on three consecutive cycles, IN_READY stays 1.
- Assert RST_N low during the EMIT_LO state → OUT_VALID=0 immediately. After release, 0x00000005 encodes as a clean single beat.

Source files
------------

// File: rtl/const_enc_pkg.sv
// Shared types and widths for the constant encoder (immediate field and beat tags).
// The signed single-beat path is selected by CONST_ENC_SIGNED_EN in the files that import this.
package const_enc_pkg;

   localparam int unsigned IM_W   = 15;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned HI_W   = 2;

   typedef enum logic [1:0] {
      SINGLE = 2'd0,
      HI     = 2'd1,
      MID    = 2'd2,
      LO     = 2'd3
   } tag_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT_MID = 2'd1,
      EMIT_LO  = 2'd2
   } state_t;

endpackage

// File: rtl/const_fit_check.sv
// Combinational classifier: does a 32-bit constant fit one zero- or sign-extended immediate?
// sign_fit is only produced when CONST_ENC_SIGNED_EN is defined; otherwise it is tied low.
module const_fit_check
   import const_enc_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   output logic              zero_fit,
   output logic              sign_fit
);

   assign zero_fit = (d[DATA_W-1:IM_W] == '0);

`ifdef CONST_ENC_SIGNED_EN
   // Upper 18 bits all ones covers -16384..-1 as a sign-extended 15-bit field.
   assign sign_fit = &d[DATA_W-1:IM_W-1];

   logic [IM_W-2:0] unused_low;
   assign unused_low = d[IM_W-2:0];
`else
   assign sign_fit = 1'b0;

   logic [IM_W-1:0] unused_low;
   assign unused_low = d[IM_W-1:0];
`endif

endmodule

// File: rtl/const_encoder.sv
// Streaming immediate encoder: splits 32-bit constants into SINGLE or HI/MID/LO immediate beats.
// Sign-fit single-beat encoding is enabled by defining CONST_ENC_SIGNED_EN.
module const_encoder
   import const_enc_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [IM_W-1:0]   OUT_IM,
   output logic              OUT_CS,
   output logic [1:0]        OUT_TAG,
   output logic              OUT_LAST
);

   localparam int unsigned HOLD_W = DATA_W - HI_W;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                valid_q, valid_d;
   logic [IM_W-1:0]     im_q, im_d;
   logic                cs_q, cs_d;
   tag_t                tag_q, tag_d;
   logic                last_q, last_d;

   logic zero_fit;
   logic sign_fit;
   logic in_fire;
   logic out_fire;

   const_fit_check u_fit (
      .d        (IN_DATA),
      .zero_fit (zero_fit),
      .sign_fit (sign_fit)
   );

   assign IN_READY = (state_q == IDLE) && (!valid_q || OUT_READY);
   assign in_fire  = IN_VALID && IN_READY;
   assign out_fire = valid_q && OUT_READY;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      im_d    = im_q;
      cs_d    = cs_q;
      tag_d   = tag_q;
      last_d  = last_q;

      unique case (state_q)
         IDLE: begin
            // A new constant overwrites the draining beat on the same edge, so no bubble.
            if (in_fire) begin
               valid_d = 1'b1;
               if (zero_fit || sign_fit) begin
                  im_d   = IN_DATA[IM_W-1:0];
                  cs_d   = !zero_fit;
                  tag_d  = SINGLE;
                  last_d = 1'b1;
               end else begin
                  im_d    = {{(IM_W-HI_W){1'b0}}, IN_DATA[DATA_W-1:HOLD_W]};
                  cs_d    = 1'b0;
                  tag_d   = HI;
                  last_d  = 1'b0;
                  hold_d  = IN_DATA[HOLD_W-1:0];
                  state_d = EMIT_MID;
               end
            end else if (out_fire) begin
               valid_d = 1'b0;
            end
         end
         EMIT_MID: begin
            if (out_fire) begin
               im_d    = hold_q[2*IM_W-1:IM_W];
               tag_d   = MID;
               state_d = EMIT_LO;
            end
         end
         EMIT_LO: begin
            if (out_fire) begin
               im_d    = hold_q[IM_W-1:0];
               tag_d   = LO;
               last_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         hold_q  <= '0;
         valid_q <= 1'b0;
         im_q    <= '0;
         cs_q    <= 1'b0;
         tag_q   <= SINGLE;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         im_q    <= im_d;
         cs_q    <= cs_d;
         tag_q   <= tag_d;
         last_q  <= last_d;
      end
   end

   assign OUT_VALID = valid_q;
   assign OUT_IM    = im_q;
   assign OUT_CS    = cs_q;
   assign OUT_TAG   = tag_q;
   assign OUT_LAST  = last_q;

endmodule

// File: tb/tb_const_encoder.sv
// Self-checking bench for const_encoder: directed scenarios plus a randomized scoreboard run.
// Expectations follow CONST_ENC_SIGNED_EN the same way as the design build.
module tb_const_encoder;

   typedef struct packed {
      logic [14:0] im;
      logic        cs;
      logic [1:0]  tag;
      logic        last;
   } beat_t;

   logic        CLK;
   logic        RST_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] IN_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [14:0] OUT_IM;
   logic        OUT_CS;
   logic [1:0]  OUT_TAG;
   logic        OUT_LAST;

   int tests = 0;
   int fails = 0;
   beat_t exp_q[$];

   const_encoder dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_IM    (OUT_IM),
      .OUT_CS    (OUT_CS),
      .OUT_TAG   (OUT_TAG),
      .OUT_LAST  (OUT_LAST)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: classify by numeric range, then split with shifts and masks.
   function automatic void model_push(input logic [31:0] d);
      beat_t b;
      longint sv;
      bit    signed_fit;
      sv = longint'($signed(d));
`ifdef CONST_ENC_SIGNED_EN
      signed_fit = (sv >= -16384) && (sv <= -1);
`else
      signed_fit = 1'b0;
`endif
      if (d < 32'd32768) begin
         b = '{im: d[14:0], cs: 1'b0, tag: 2'd0, last: 1'b1};
         exp_q.push_back(b);
      end else if (signed_fit) begin
         b = '{im: 15'(d & 32'h7FFF), cs: 1'b1, tag: 2'd0, last: 1'b1};
         exp_q.push_back(b);
      end else begin
         b = '{im: 15'(d >> 30), cs: 1'b0, tag: 2'd1, last: 1'b0};
         exp_q.push_back(b);
         b = '{im: 15'((d >> 15) & 32'h7FFF), cs: 1'b0, tag: 2'd2, last: 1'b0};
         exp_q.push_back(b);
         b = '{im: 15'(d & 32'h7FFF), cs: 1'b0, tag: 2'd3, last: 1'b1};
         exp_q.push_back(b);
      end
   endfunction

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
      step; step;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== 20'd0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b im=%h cs=%b tag=%0d last=%b, want all zero",
                  OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST);
      end
      #3 RST_N = 1'b1;
      step;
      tests++;
      if (IN_READY !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready: got %b want 1", IN_READY);
      end
   endtask

   task automatic test_single;
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h0000_1234;
      step;
      IN_VALID = 1'b0;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== {1'b1, 15'h1234, 1'b0, 2'd0, 1'b1}) begin
         fails++;
         $display("FAIL single_0x1234: got v=%b im=%h cs=%b tag=%0d last=%b, want v=1 im=1234 cs=0 tag=0 last=1",
                  OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST);
      end
      step;
      tests++;
      if (OUT_VALID !== 1'b0) begin
         fails++; $display("FAIL single_drain: OUT_VALID got %b want 0", OUT_VALID);
      end
   endtask

   // Three-beat constant with OUT_READY high: checks beats, LAST, and IN_READY per beat.
   task automatic run_three(input logic [31:0] d, input logic [14:0] hi, input logic [14:0] mid,
                            input logic [14:0] lo);
      logic [14:0] ims [3];
      ims[0] = hi; ims[1] = mid; ims[2] = lo;
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = d;
      step;
      IN_VALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== {1'b1, ims[k], 1'b0, 2'(k + 1), (k == 2)}) begin
            fails++;
            $display("FAIL multi_%h_beat%0d: got v=%b im=%h cs=%b tag=%0d last=%b, want im=%h tag=%0d",
                     d, k, OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST, ims[k], k + 1);
         end
         tests++;
         if (IN_READY !== (k == 2)) begin
            fails++;
            $display("FAIL multi_%h_in_ready%0d: got %b want %b", d, k, IN_READY, (k == 2));
         end
         step;
      end
      tests++;
      if (OUT_VALID !== 1'b0) begin
         fails++; $display("FAIL multi_%h_drain: OUT_VALID got %b want 0", d, OUT_VALID);
      end
   endtask

   task automatic test_multi;
      run_three(32'hDEAD_BEEF, 15'h0003, 15'h3D5B, 15'h3EEF);
      run_three(32'h0000_8000, 15'h0000, 15'h0001, 15'h0000);
   endtask

   task automatic test_signed;
`ifdef CONST_ENC_SIGNED_EN
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'hFFFF_C000;
      step;
      IN_VALID = 1'b0;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== {1'b1, 15'h4000, 1'b1, 2'd0, 1'b1}) begin
         fails++;
         $display("FAIL signed_fit: got v=%b im=%h cs=%b tag=%0d last=%b, want im=4000 cs=1 tag=0 last=1",
                  OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST);
      end
      step;
`else
      run_three(32'hFFFF_C000, 15'h0003, 15'h7FFF, 15'h4000);
`endif
      // 16384..32767 must stay zero-extended
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'h0000_7FFF;
      step;
      IN_VALID = 1'b0;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG} !== {1'b1, 15'h7FFF, 1'b0, 2'd0}) begin
         fails++;
         $display("FAIL zero_fit_7fff: got v=%b im=%h cs=%b tag=%0d, want im=7fff cs=0 tag=0",
                  OUT_VALID, OUT_IM, OUT_CS, OUT_TAG);
      end
      step;
   endtask

   task automatic test_backpressure;
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'hDEAD_BEEF;
      step;
      IN_VALID = 1'b0;
      step;
      OUT_READY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++;
         if ({OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST, IN_READY} !== {1'b1, 15'h3D5B, 2'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL backpressure_mid%0d: got v=%b im=%h tag=%0d last=%b in_ready=%b, want v=1 im=3d5b tag=2 last=0 in_ready=0",
                     k, OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST, IN_READY);
         end
         step;
      end
      OUT_READY = 1'b1;
      step;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST} !== {1'b1, 15'h3EEF, 2'd3, 1'b1}) begin
         fails++;
         $display("FAIL backpressure_lo: got v=%b im=%h tag=%0d last=%b, want v=1 im=3eef tag=3 last=1",
                  OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST);
      end
      step;
   endtask

   task automatic test_back_to_back;
      OUT_READY = 1'b1; IN_VALID = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         IN_DATA = 32'(k);
         #1;
         tests++;
         if (IN_READY !== 1'b1) begin
            fails++; $display("FAIL b2b_in_ready%0d: got %b want 1", k, IN_READY);
         end
         step;
         tests++;
         if ({OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST} !== {1'b1, 15'(k), 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL b2b_beat%0d: got v=%b im=%h tag=%0d last=%b, want v=1 im=%h tag=0 last=1",
                     k, OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST, k);
         end
      end
      IN_VALID = 1'b0;
      step;
   endtask

   task automatic test_reset_mid;
      OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'hDEAD_BEEF;
      step;
      IN_VALID = 1'b0;
      step;
      RST_N = 1'b0;
      #1;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST} !== 19'd0) begin
         fails++;
         $display("FAIL reset_mid_async: got v=%b im=%h tag=%0d last=%b, want all zero",
                  OUT_VALID, OUT_IM, OUT_TAG, OUT_LAST);
      end
      step;
      RST_N = 1'b1;
      IN_VALID = 1'b1; IN_DATA = 32'h0000_0005;
      step;
      IN_VALID = 1'b0;
      tests++;
      if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== {1'b1, 15'h0005, 1'b0, 2'd0, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_after: got v=%b im=%h cs=%b tag=%0d last=%b, want im=0005 tag=0 last=1",
                  OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST);
      end
      step;
      tests++;
      if (OUT_VALID !== 1'b0) begin
         fails++; $display("FAIL reset_mid_no_partial: OUT_VALID got %b want 0", OUT_VALID);
      end
   endtask

   function automatic logic [31:0] rand_data;
      logic [31:0] edges [8];
      edges = '{32'h0000_3FFF, 32'h0000_4000, 32'h0000_7FFF, 32'h0000_8000,
                32'hFFFF_BFFF, 32'hFFFF_C000, 32'hFFFF_FFFF, 32'h8000_0000};
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 32767));
         1:       return 32'hFFFF_C000 | 32'($urandom_range(0, 16383));
         2:       return edges[$urandom_range(0, 7)];
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random;
      beat_t e;
      beat_t prev;
      logic  stall_prev = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         IN_VALID  = ($urandom_range(0, 3) != 0);
         OUT_READY = ($urandom_range(0, 3) != 0);
         IN_DATA   = rand_data();
         #1;
         if (stall_prev) begin
            tests++;
            if ({OUT_VALID, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== {1'b1, prev}) begin
               fails++;
               $display("FAIL rand_hold c%0d: got v=%b beat=%h, want v=1 beat=%h", c, OUT_VALID,
                        {OUT_IM, OUT_CS, OUT_TAG, OUT_LAST}, prev);
            end
         end
         tests++;
         if (IN_READY !== ((exp_q.size() <= 1) && (!OUT_VALID || OUT_READY))) begin
            fails++;
            $display("FAIL rand_in_ready c%0d: got %b pending=%0d", c, IN_READY, exp_q.size());
         end
         if (OUT_VALID) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rand_unexpected c%0d: beat=%h with nothing pending", c,
                        {OUT_IM, OUT_CS, OUT_TAG, OUT_LAST});
            end else begin
               e = exp_q[0];
               if ({OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== e) begin
                  fails++;
                  $display("FAIL rand_beat c%0d: got im=%h cs=%b tag=%0d last=%b, want im=%h cs=%b tag=%0d last=%b",
                           c, OUT_IM, OUT_CS, OUT_TAG, OUT_LAST, e.im, e.cs, e.tag, e.last);
               end
               if (OUT_READY) void'(exp_q.pop_front());
            end
         end
         if (IN_VALID && IN_READY) model_push(IN_DATA);
         stall_prev = OUT_VALID && !OUT_READY;
         prev = '{im: OUT_IM, cs: OUT_CS, tag: OUT_TAG, last: OUT_LAST};
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (OUT_VALID && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({OUT_IM, OUT_CS, OUT_TAG, OUT_LAST} !== e) begin
               fails++;
               $display("FAIL rand_drain c%0d: got beat=%h want %h", c, {OUT_IM, OUT_CS, OUT_TAG, OUT_LAST}, e);
            end
         end
         step;
      end
      tests++;
      if (exp_q.size() != 0 || OUT_VALID !== 1'b0) begin
         fails++;
         $display("FAIL rand_leftover: pending=%0d OUT_VALID=%b, want 0 and 0", exp_q.size(), OUT_VALID);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_signed;
      test_multi;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
